// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Pipeline hazard/stall controller sitting beside the ID stage of the
//   5-stage MIPS core. It handles three things:
//     - load-use stalls that last LOAD_LAT cycles,
//     - a HI/LO interlock against the iterative mul/div unit,
//     - a flush override that releases any stall in the same cycle.
//   It also keeps a saturating count of stalled cycles.
//
// Parameters
//   REG_W    register-index width
//   LOAD_LAT total stall cycles per load-use hazard (1..15)
//   CNT_W    width of the stall performance counter
//
// Ports
//   clk, rst_n        pipeline clock (rising edge), async active-low reset
//   id_rega/id_regb   rs/rt indices of the instruction in ID
//   id_use_hilo       ID instruction reads HI/LO or issues mul/div
//   ex_dreg/ex_we     destination register and write enable in EX
//   ex_is_load        EX instruction is a register-writing load
//   md_start/md_done  mul/div launch and completion pulses
//   flush             branch/exception flush of IF/ID
//   stall_n           0 = hold PC and IF/ID
//   bubble            1 = insert a NOP into ID/EX (always ~stall_n)
//   state             debug view of the FSM state
//   stall_cnt         saturating count of cycles with stall_n = 0
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | no multi-cycle stall in progress; hazards evaluated
// LOAD_WAIT | remaining cycles of a multi-cycle load-use stall
// MD_WAIT   | ID instruction waits for mul/div to write HI/LO

module hazard_stall_unit #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rega,
  input  logic [REG_W-1:0] id_regb,
  input  logic             id_use_hilo,
  input  logic [REG_W-1:0] ex_dreg,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic             md_start,
  input  logic             md_done,
  input  logic             flush,
  output logic             stall_n,
  output logic             bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_MD_WAIT   = 2'd2
  } state_t;

  // rem counts the stall cycles still owed after the detection cycle
  localparam logic [3:0] LP_REM_INIT = 4'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [3:0]       r_rem;
  logic             r_md_busy;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_load_haz;
  logic w_md_haz;
  logic w_stall;

  assign w_load_haz = ex_we & ex_is_load & (ex_dreg != '0) &
                      ((ex_dreg == id_rega) | (ex_dreg == id_regb));
  // md_done in the same cycle means HI/LO is written now; no need to wait
  assign w_md_haz   = r_md_busy & id_use_hilo & ~md_done;

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:      w_stall = ~flush & (w_md_haz | w_load_haz);
      S_LOAD_WAIT: w_stall = ~flush;
      S_MD_WAIT:   w_stall = ~flush & ~md_done;
      default:     w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!flush) begin
            if (w_md_haz) begin
              r_state <= S_MD_WAIT;
            end else if (w_load_haz && (LOAD_LAT > 1)) begin
              r_rem   <= LP_REM_INIT;
              r_state <= S_LOAD_WAIT;
            end
          end
        end
        S_LOAD_WAIT: begin
          // the load has already left EX, so hazards are not re-checked here
          if (flush) begin
            r_rem   <= 4'd0;
            r_state <= S_IDLE;
          end else begin
            r_rem <= r_rem - 4'd1;
            if (r_rem == 4'd1) r_state <= S_IDLE;
          end
        end
        S_MD_WAIT: begin
          if (flush || md_done) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_rem   <= 4'd0;
        end
      endcase
    end
  end

  // a start coinciding with a done belongs to a new operation, so set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_md_busy <= 1'b0;
    else if (md_start) r_md_busy <= 1'b1;
    else if (md_done)  r_md_busy <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
  end

  assign stall_n   = ~w_stall;
  assign bubble    = w_stall;
  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Parametrised pipeline hazard/stall controller for the 5-stage MIPS core. It supersedes the purely combinational single-cycle load-use stall. It adds three things: a configurable multi-cycle load latency held by a down-counter FSM, HI/LO interlock against the iterative multiply/divide unit, and a flush override. A saturating stall-cycle performance counter is also provided. It sits beside the ID stage. `stall_n` gates the PC and IF/ID registers, and `bubble` zeroes the ID/EX control word.

## Interface

Parameters:

- REG_W, 5, register-index width.
- LOAD_LAT, 1, total stall cycles per load-use hazard; legal range 1..15.
- CNT_W, 32, width of the stall performance counter.

Ports:

- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- id_rega  in  REG_W  rs index of the instruction in ID.
- id_regb  in  REG_W  rt index of the instruction in ID.
- id_use_hilo  in  1  the ID instruction reads HI/LO or issues mul/div.
- ex_dreg  in  REG_W  destination register of the instruction in EX.
- ex_we  in  1  the EX instruction writes the register file.
- ex_is_load  in  1  the EX instruction is a register-writing load (lw/lh/lb class, decoded upstream).
- md_start  in  1  single-cycle pulse: a mul/div operation is launched from EX.
- md_done  in  1  single-cycle pulse: the mul/div result is written to HI/LO.
- flush  in  1  branch/exception flush of IF/ID.
- stall_n  out  1  0 = stall (hold PC and IF/ID).
- bubble  out  1  1 = insert a NOP into ID/EX; always equals ~stall_n.
- state  out  2  FSM state for debug: 0 IDLE, 1 LOAD_WAIT, 2 MD_WAIT.
- stall_cnt  out  CNT_W  number of cycles with stall_n=0 since reset.

## Operation

Terms:

- load_haz = ex_we & ex_is_load & (ex_dreg != 0) & (ex_dreg == id_rega | ex_dreg == id_regb).
- md_haz = md_busy & id_use_hilo & ~md_done.

md_busy register:

- Set by md_start, cleared by md_done.
- If both pulse in the same cycle, md_busy = 1 (the new operation wins).
- flush does not affect md_busy.

FSM, evaluated with priority flush > md > load:

- IDLE:
  - flush: stall_n=1, stay in IDLE.
  - else md_haz: stall_n=0, go to MD_WAIT.
  - else load_haz: stall_n=0. If LOAD_LAT>1, load rem=LOAD_LAT-1 and go to LOAD_WAIT; otherwise stay in IDLE.
  - else stall_n=1.
- LOAD_WAIT:
  - flush: stall_n=1, go to IDLE, clear rem.
  - else: stall_n=0. If rem==1 go to IDLE, else rem-=1.
  - Hazards are not re-evaluated in this state; the load has left EX.
- MD_WAIT:
  - flush: stall_n=1, go to IDLE.
  - else md_done=1: stall_n=1 in that cycle, go to IDLE.
  - else stall_n=0, stay.

Outputs:

- stall_n and bubble are combinational from the current state, rem and the inputs.
- state, rem, md_busy and stall_cnt are registered.

stall_cnt:

- Increments by 1 on each rising edge where stall_n=0.
- Saturates at 2^CNT_W-1 and never wraps.

Reset:

- state=IDLE, rem=0, md_busy=0, stall_cnt=0.
- With all inputs 0: stall_n=1, bubble=0.
- An assertion of rst_n mid-stall releases the stall immediately, asynchronously.

## Timing

- Load-use hazard: exactly LOAD_LAT consecutive stall cycles. The first is the detection cycle; the ID instruction proceeds on the following edge.
- LOAD_LAT=1 is cycle-identical to the legacy single-cycle load-use stall.
- HI/LO interlock: stall from the first cycle md_haz is seen until the cycle md_done=1 (exclusive), so the dependent instruction leaves ID in the md_done cycle.
- flush takes effect in the same cycle (combinational release). The FSM returns to IDLE on the next edge.
- No combinational path from stall_n back to any input of this block.

## Test plan

- Reset/idle: hold rst_n=0, then release with all inputs 0 -> stall_n=1, bubble=0, state=0, stall_cnt=0.
- LOAD_LAT=1: ex_we=1, ex_is_load=1, ex_dreg=8, id_rega=8 for one cycle -> stall_n=0 for 1 cycle, state stays 0, stall_cnt=1. Repeat with ex_dreg=0 -> no stall.
- LOAD_LAT=3: hazard pulse on ex_dreg=9, id_regb=9 -> stall_n=0 for exactly 3 cycles, state sequence 0,1,1,0, stall_cnt=3. Assert flush in the 2nd stall cycle -> stall_n=1 in that cycle, state=0 on the next edge, stall_cnt=1.
- HI/LO: md_start pulse, then id_use_hilo=1 two cycles later, md_done 5 cycles after start -> stall_n=0 from the id_use_hilo cycle until md_done, 1 in the md_done cycle, state 2 then 0. md_start and md_done in the same cycle -> md_busy stays 1.
- Priority: md_haz and load_haz together -> state goes to MD_WAIT. flush together with both -> no stall.
- Saturation with CNT_W=4: 20 stall cycles -> stall_cnt=15 and holds. Assert rst_n=0 mid-LOAD_WAIT -> stall_n=1 immediately, state=0.
